// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared NoC network-interface definitions: flit type encodings and packet
// sizing helpers used by the response flitizer and future AW/AR packetizers.
package axi4_duth_noc_ni_pkg;

   localparam int FLIT_TYPE_W = 2;

   // Bit 1 marks a head flit, bit 0 marks a tail flit.
   typedef enum logic [FLIT_TYPE_W-1:0] {
      BODY   = 2'b00,
      TAIL   = 2'b01,
      HEAD   = 2'b10,
      SINGLE = 2'b11
   } flit_type_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } flitizer_state_t;

   function automatic int get_flits_per_resp(input int link_width, input int chan_w,
                                             input int header_full, input int header_small);
      int pf;
      int ps;
      pf = link_width - header_full;
      ps = link_width - header_small;
      if (chan_w <= pf) return 1;
      return 1 + (chan_w - pf + ps - 1) / ps;
   endfunction

   // Number of zero bits appended above the payload in the last flit.
   function automatic int get_resp_flit_pad_last(input int link_width, input int chan_w,
                                                 input int header_full, input int header_small);
      int n;
      n = get_flits_per_resp(link_width, chan_w, header_full, header_small);
      return (link_width - header_full) + (n - 1) * (link_width - header_small) - chan_w;
   endfunction

endpackage

// File: rtl/axi4_duth_noc_ni_resp_flitizer_if.sv
// Handshake bundle between the response capture (beat side) and the NoC
// injection port (flit side) of the response flitizer.
interface axi4_duth_noc_ni_resp_flitizer_if #(
   parameter int LINK_WIDTH = 64,
   parameter int CHAN_W     = 35,
   parameter int DST_W      = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [CHAN_W-1:0]     in_data;
   logic [DST_W-1:0]      in_dst;
   logic                  out_valid;
   logic                  out_ready;
   logic [LINK_WIDTH-1:0] out_flit;

   modport master (
      output in_valid, in_data, in_dst, out_ready,
      input  in_ready, out_valid, out_flit
   );

   modport slave (
      input  in_valid, in_data, in_dst, out_ready,
      output in_ready, out_valid, out_flit
   );
endinterface

// File: rtl/axi4_duth_noc_ni_resp_flitizer.sv
// Serializes one ID-stripped AXI response beat into a HEAD/BODY/TAIL (or
// SINGLE) flit packet, one flit per cycle, with back-to-back beat acceptance.
module axi4_duth_noc_ni_resp_flitizer
   import axi4_duth_noc_ni_pkg::*;
#(
   parameter int LINK_WIDTH = 64,
   parameter int CHAN_W     = 35,
   parameter int DST_W      = 4
) (
   input  logic clk,
   input  logic rst,
   axi4_duth_noc_ni_resp_flitizer_if.slave bus
);

   localparam int HEADER_FULL  = FLIT_TYPE_W + DST_W;
   localparam int HEADER_SMALL = FLIT_TYPE_W;
   localparam int N_FLITS      = get_flits_per_resp(LINK_WIDTH, CHAN_W, HEADER_FULL, HEADER_SMALL);
   localparam int PAD_LAST     = get_resp_flit_pad_last(LINK_WIDTH, CHAN_W, HEADER_FULL, HEADER_SMALL);
   localparam int PF           = LINK_WIDTH - HEADER_FULL;
   localparam int PS           = LINK_WIDTH - HEADER_SMALL;
   localparam int TOTAL_W      = CHAN_W + PAD_LAST;
   localparam int IDX_W        = $clog2(N_FLITS + 1);
   localparam int BEAT_W       = DST_W + CHAN_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FLITS - 1);

   flitizer_state_t       state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [BEAT_W-1:0]     beat_q, beat_d;
   logic [CHAN_W-1:0]     data_q;
   logic [DST_W-1:0]      dst_q;
   logic [TOTAL_W-1:0]    payload;
   logic [LINK_WIDTH-1:0] flits [N_FLITS];
   logic [LINK_WIDTH-1:0] flit_sel;
   logic                  in_ready;
   logic                  out_valid;

   assign {dst_q, data_q} = beat_q;
   assign payload         = TOTAL_W'(data_q);

   // Each flit slot is wired statically; the padding above CHAN_W comes from the zero extension.
   for (genvar k = 0; k < N_FLITS; k++) begin : g_flit
      if (k == 0) begin : g_head
         localparam flit_type_t T = (N_FLITS == 1) ? SINGLE : HEAD;
         assign flits[k] = {T, dst_q, payload[PF-1:0]};
      end else begin : g_rest
         localparam flit_type_t T = (k == N_FLITS - 1) ? TAIL : BODY;
         assign flits[k] = {T, payload[PF+(k-1)*PS +: PS]};
      end
   end

   always_comb begin
      flit_sel = '0;
      for (int k = 0; k < N_FLITS; k++) begin
         if (idx_q == IDX_W'(k)) flit_sel = flits[k];
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      beat_d    = beat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (bus.in_valid) begin
               beat_d  = {bus.in_dst, bus.in_data};
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            if (bus.out_ready) begin
               if (idx_q == LAST_IDX) begin
                  // Tail leaves this cycle, so a waiting beat can follow without a bubble.
                  in_ready = 1'b1;
                  idx_d    = '0;
                  if (bus.in_valid) begin
                     beat_d = {bus.in_dst, bus.in_data};
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         beat_q  <= beat_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_flit  = (state_q == SEND) ? flit_sel : '0;

endmodule

// File: tb/tb_axi4_duth_noc_ni_resp_flitizer.sv
// Scoreboard bench for the response flitizer: a 3-flit config (CHAN_W=35) and
// a single-flit config (CHAN_W=8) on a 16-bit link.
module tb_axi4_duth_noc_ni_resp_flitizer;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] qA[$];
   logic [15:0] qB[$];

   axi4_duth_noc_ni_resp_flitizer_if #(.LINK_WIDTH(16), .CHAN_W(35), .DST_W(4)) ifA ();
   axi4_duth_noc_ni_resp_flitizer_if #(.LINK_WIDTH(16), .CHAN_W(8),  .DST_W(4)) ifB ();

   axi4_duth_noc_ni_resp_flitizer #(.LINK_WIDTH(16), .CHAN_W(35), .DST_W(4)) dutA (
      .clk (clk),
      .rst (rst),
      .bus (ifA)
   );

   axi4_duth_noc_ni_resp_flitizer #(.LINK_WIDTH(16), .CHAN_W(8), .DST_W(4)) dutB (
      .clk (clk),
      .rst (rst),
      .bus (ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] modelA(input logic [34:0] d, input logic [3:0] dst, input int k);
      case (k)
         0:       return {2'b10, dst, d[9:0]};
         1:       return {2'b00, d[23:10]};
         default: return {2'b01, 3'b000, d[34:24]};
      endcase
   endfunction

   task automatic pushA(input logic [34:0] d, input logic [3:0] dst);
      for (int k = 0; k < 3; k++) qA.push_back(modelA(d, dst, k));
   endtask

   task automatic applyStimulus(input logic [34:0] d, input logic [3:0] dst);
      ifA.in_valid = 1'b1;
      ifA.in_data  = d;
      ifA.in_dst   = dst;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every accepted flit is matched against the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (ifA.out_valid && ifA.out_ready) begin
            if (qA.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL A_unexpected: got=%h expected=none", ifA.out_flit);
            end else begin
               checkOutput("A_flit", 64'(ifA.out_flit), 64'(qA.pop_front()));
            end
         end
         if (ifB.out_valid && ifB.out_ready) begin
            if (qB.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL B_unexpected: got=%h expected=none", ifB.out_flit);
            end else begin
               checkOutput("B_flit", 64'(ifB.out_flit), 64'(qB.pop_front()));
            end
         end
      end
   end

   initial begin
      logic [34:0] dA;
      logic [3:0]  dstA;
      logic [1:0]  typ;
      rst           = 1'b1;
      ifA.in_valid  = 1'b0;
      ifA.in_data   = '0;
      ifA.in_dst    = '0;
      ifA.out_ready = 1'b1;
      ifB.in_valid  = 1'b0;
      ifB.in_data   = '0;
      ifB.in_dst    = '0;
      ifB.out_ready = 1'b1;
      repeat (3) tick();
      checkOutput("rst_out_valid", 64'(ifA.out_valid), 64'd0);
      checkOutput("rst_out_flit",  64'(ifA.out_flit),  64'd0);
      checkOutput("rst_in_ready",  64'(ifA.in_ready),  64'd1);
      rst = 1'b0;
      tick();

      $display("[TB] basic 3-flit packet");
      qA.push_back(16'hA5A5);
      qA.push_back(16'h2969);
      qA.push_back(16'h45A5);
      applyStimulus(35'h5_A5A5_A5A5, 4'h9);
      tick();
      ifA.in_valid = 1'b0;
      checkOutput("lat_valid", 64'(ifA.out_valid), 64'd1);
      checkOutput("lat_head",  64'(ifA.out_flit),  64'hA5A5);
      tick();
      checkOutput("flit1_valid", 64'(ifA.out_valid), 64'd1);
      tick();
      checkOutput("flit2_valid", 64'(ifA.out_valid), 64'd1);
      tick();
      checkOutput("basic_idle", 64'(ifA.out_valid), 64'd0);

      $display("[TB] backpressure with ignored in_valid pulses");
      dA   = 35'h1_2345_6789;
      dstA = 4'h3;
      pushA(dA, dstA);
      applyStimulus(dA, dstA);
      tick();
      ifA.in_valid = 1'b0;
      tick();
      ifA.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bp_flit",    64'(ifA.out_flit),  64'(modelA(dA, dstA, 1)));
         checkOutput("bp_valid",   64'(ifA.out_valid), 64'd1);
         checkOutput("bp_inready", 64'(ifA.in_ready),  64'd0);
         ifA.in_valid = (i == 1 || i == 2);
         ifA.in_data  = 35'h7_FFFF_0000;
         ifA.in_dst   = 4'hE;
         tick();
      end
      ifA.in_valid  = 1'b0;
      ifA.out_ready = 1'b1;
      tick();
      checkOutput("bp_resume", 64'(ifA.out_flit), 64'(modelA(dA, dstA, 2)));
      tick();
      checkOutput("bp_no_accept", 64'(ifA.out_valid), 64'd0);

      $display("[TB] back-to-back beats");
      pushA(35'h2_AAAA_5555, 4'h5);
      pushA(35'h4_1357_9BDF, 4'hA);
      applyStimulus(35'h2_AAAA_5555, 4'h5);
      tick();
      applyStimulus(35'h4_1357_9BDF, 4'hA);
      for (int i = 0; i < 6; i++) begin
         checkOutput("b2b_valid", 64'(ifA.out_valid), 64'd1);
         if (i == 0) checkOutput("b2b_ready_head", 64'(ifA.in_ready), 64'd0);
         if (i == 2) checkOutput("b2b_ready_tail", 64'(ifA.in_ready), 64'd1);
         tick();
         if (i == 2) ifA.in_valid = 1'b0;
      end
      checkOutput("b2b_idle", 64'(ifA.out_valid), 64'd0);

      $display("[TB] single-flit config");
      ifB.in_valid = 1'b1;
      ifB.in_data  = 8'h3C;
      ifB.in_dst   = 4'h7;
      qB.push_back({2'b11, 4'h7, 2'b00, 8'h3C});
      tick();
      for (int j = 1; j < 3; j++) begin
         checkOutput("single_valid", 64'(ifB.out_valid), 64'd1);
         checkOutput("single_ready", 64'(ifB.in_ready),  64'd1);
         ifB.in_data = (j == 1) ? 8'hA1 : 8'h5E;
         ifB.in_dst  = (j == 1) ? 4'h2 : 4'hF;
         qB.push_back({2'b11, ifB.in_dst, 2'b00, ifB.in_data});
         tick();
      end
      ifB.in_valid = 1'b0;
      checkOutput("single_last", 64'(ifB.out_valid), 64'd1);
      tick();
      checkOutput("single_idle", 64'(ifB.out_valid), 64'd0);

      $display("[TB] reset mid-packet");
      dA   = 35'h7_0F0F_1234;
      dstA = 4'hC;
      pushA(dA, dstA);
      applyStimulus(dA, dstA);
      tick();
      ifA.in_valid = 1'b0;
      tick();
      ifA.out_ready = 1'b0;
      checkOutput("rst_pre_flit", 64'(ifA.out_flit), 64'(modelA(dA, dstA, 1)));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      qA.delete();
      checkOutput("midrst_valid",   64'(ifA.out_valid), 64'd0);
      checkOutput("midrst_inready", 64'(ifA.in_ready),  64'd1);
      checkOutput("midrst_flit",    64'(ifA.out_flit),  64'd0);
      ifA.out_ready = 1'b1;
      pushA(35'h0_1111_2222, 4'h1);
      applyStimulus(35'h0_1111_2222, 4'h1);
      tick();
      ifA.in_valid = 1'b0;
      typ = ifA.out_flit[15:14];
      checkOutput("fresh_head_type", 64'(typ), 64'(2'b10));
      repeat (3) tick();
      checkOutput("fresh_idle", 64'(ifA.out_valid), 64'd0);

      for (int i = 0; i < 20 && (qA.size() != 0 || qB.size() != 0); i++) tick();
      if (qA.size() != 0 || qB.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: left=%0d expected=0", qA.size() + qB.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
